// File: rtl/lfsr_gen.sv
// Fibonacci LFSR with seed loading, valid/ready output and period tracking.
// Period tracking is built only when LFSR_GEN_PERIOD_EN is defined.
module lfsr_gen #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(32'hEA000001),
    parameter int               STEPS        = 1,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] out,
    output logic [7:0]       out_lb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             period_done,
    output logic [31:0]      period_len
);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] seed_val;
    logic             adv;

    assign adv      = enable & ~seed_load & (~out_valid | out_ready);
    assign seed_val = (seed_in == '0) ? SEED_DEFAULT : seed_in;

    always_comb begin
        nxt = state;
        for (int i = 0; i < STEPS; i++) begin
            nxt = {^(nxt & TAPS), nxt[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEED_DEFAULT;
            out_valid <= 1'b0;
        end else if (seed_load) begin
            state     <= seed_val;
            out_valid <= 1'b0;
        end else if (adv) begin
            state     <= nxt;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out    = state;
    assign out_lb = state[7:0];

`ifdef LFSR_GEN_PERIOD_EN
    logic [31:0]      step_cnt;
    logic [WIDTH-1:0] seed_act;

    // Count advances since the active seed; a return to it closes the period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt    <= '0;
            seed_act    <= SEED_DEFAULT;
            period_done <= 1'b0;
            period_len  <= '0;
        end else begin
            period_done <= 1'b0;
            if (seed_load) begin
                seed_act <= seed_val;
                step_cnt <= '0;
            end else if (adv) begin
                if (nxt == seed_act) begin
                    period_done <= 1'b1;
                    period_len  <= step_cnt + 32'd1;
                    step_cnt    <= '0;
                end else begin
                    step_cnt <= step_cnt + 32'd1;
                end
            end
        end
    end
`else
    assign period_done = 1'b0;
    assign period_len  = '0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: default, STEPS=2 and 8-bit instances.
// Period checks follow LFSR_GEN_PERIOD_EN.
module tb_lfsr_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        seed_load = 1'b0;
    logic [31:0] seed_in = '0;
    logic        out_ready = 1'b0;
    logic [31:0] out;
    logic [7:0]  out_lb;
    logic        out_valid;
    logic        period_done;
    logic [31:0] period_len;

    logic        en2 = 1'b0;
    logic        rdy2 = 1'b0;
    logic [31:0] out2;
    logic [7:0]  lb2;
    logic        v2;
    logic        pd2;
    logic [31:0] pl2;

    logic        en8 = 1'b0;
    logic        rdy8 = 1'b0;
    logic [7:0]  out8;
    logic [7:0]  lb8;
    logic        v8;
    logic        pd8;
    logic [31:0] pl8;

    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_gen dut (
        .clk(clk), .rst(rst), .enable(enable),
        .seed_load(seed_load), .seed_in(seed_in),
        .out(out), .out_lb(out_lb), .out_valid(out_valid),
        .out_ready(out_ready), .period_done(period_done),
        .period_len(period_len)
    );

    lfsr_gen #(.STEPS(2)) dut2 (
        .clk(clk), .rst(rst), .enable(en2),
        .seed_load(1'b0), .seed_in(32'h0),
        .out(out2), .out_lb(lb2), .out_valid(v2),
        .out_ready(rdy2), .period_done(pd2),
        .period_len(pl2)
    );

    lfsr_gen #(.WIDTH(8), .TAPS(8'h03), .SEED_DEFAULT(8'h01)) dut8 (
        .clk(clk), .rst(rst), .enable(en8),
        .seed_load(1'b0), .seed_in(8'h00),
        .out(out8), .out_lb(lb8), .out_valid(v8),
        .out_ready(rdy8), .period_done(pd8),
        .period_len(pl8)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] step8(input logic [7:0] s);
        return {^(s & 8'h03), s[7:1]};
    endfunction

    // Monitor: every accepted word must match the oldest expectation.
    always @(negedge clk) begin : mon
        logic [31:0] e;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: got %h expected no word", out);
            end else begin
                e = exp_q.pop_front();
                if (out !== e) begin
                    errors++;
                    $display("FAIL sb_word: got %h expected %h", out, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p;
        logic [7:0] s;

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", out, 32'h00000001);
        chk("rst_lb", 32'(out_lb), 32'h01);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_pdone", 32'(period_done), 32'h0);
        chk("rst_plen", period_len, 32'h0);
        rst = 1'b0;

        // Free run, three advances
        @(posedge clk); #1;
        out_ready = 1'b1;
        enable = 1'b1;
        exp_q.push_back(32'h80000000);
        exp_q.push_back(32'hC0000000);
        exp_q.push_back(32'h60000000);
        repeat (3) @(posedge clk);
        #1 enable = 1'b0;
        chk("run_out", out, 32'h60000000);
        chk("run_lb", 32'(out_lb), 32'h00);
        @(posedge clk); #1;
        chk("run_drain", 32'(out_valid), 32'h0);

        // Zero seed substitution, load beats enable
        seed_load = 1'b1;
        seed_in = 32'h0;
        enable = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        chk("zseed_out", out, 32'h00000001);
        chk("zseed_valid", 32'(out_valid), 32'h0);
        chk("zseed_pdone", 32'(period_done), 32'h0);

        // Backpressure hold
        out_ready = 1'b0;
        exp_q.push_back(32'h80000000);
        @(posedge clk); #1;
        chk("bp_first", out, 32'h80000000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold", out, 32'h80000000);
            chk("bp_valid", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        exp_q.push_back(32'hC0000000);
        @(posedge clk); #1;
        enable = 1'b0;
        chk("bp_release", out, 32'hC0000000);
        @(posedge clk); #1;
        chk("bp_drain", 32'(out_valid), 32'h0);

        // Explicit seed then one advance
        seed_load = 1'b1;
        seed_in = 32'h12345678;
        enable = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        chk("seed_out", out, 32'h12345678);
        chk("seed_valid", 32'(out_valid), 32'h0);
        chk("seed_pdone", 32'(period_done), 32'h0);
        exp_q.push_back(32'h891A2B3C);
        @(posedge clk); #1;
        enable = 1'b0;
        @(posedge clk); #1;
        chk("seed_drain", 32'(out_valid), 32'h0);

        // STEPS=2 instance
        chk("s2_init", out2, 32'h00000001);
        en2 = 1'b1;
        rdy2 = 1'b1;
        @(posedge clk); #1;
        en2 = 1'b0;
        chk("s2_adv", out2, 32'hC0000000);
        chk("s2_valid", 32'(v2), 32'h1);
        @(posedge clk); #1;
        chk("s2_drain", 32'(v2), 32'h0);

        // 8-bit instance period
        s = 8'h01;
        p = 0;
        do begin
            s = step8(s);
            p++;
        end while (s != 8'h01 && p < 1000);
        en8 = 1'b1;
        rdy8 = 1'b1;
`ifdef LFSR_GEN_PERIOD_EN
        for (int k = 1; k <= 2 * p; k++) begin
            @(posedge clk); @(negedge clk);
            chk("p8_done", 32'(pd8), 32'((k % p) == 0));
            if ((k % p) == 0) begin
                chk("p8_len", pl8, 32'(p));
                chk("p8_seed", 32'(out8), 32'h01);
            end
        end
`else
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); @(negedge clk);
            chk("p8_done_off", 32'(pd8), 32'h0);
        end
        chk("p8_len_off", pl8, 32'h0);
`endif
        en8 = 1'b0;

        // Asynchronous reset mid-stream
        @(posedge clk); #1;
        enable = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(32'h448D159E);
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_out", out, 32'h00000001);
        chk("arst_lb", 32'(out_lb), 32'h01);
        chk("arst_valid", 32'(out_valid), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(32'h80000000);
        exp_q.push_back(32'hC0000000);
        repeat (2) @(posedge clk);
        #1 enable = 1'b0;
        chk("arst_restart", out, 32'hC0000000);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_leftover", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
